// File: rtl/cache_pkg.sv
// Shared widths and FSM state encodings for the direct-mapped cache controller.
package cache_pkg;

  localparam int unsigned ADDRESS_LEN = 18;
  localparam int unsigned WORD_LEN    = 32;
  localparam int unsigned BLOCK_WORDS = 4;
  localparam int unsigned BLOCK_LEN   = BLOCK_WORDS * WORD_LEN;
  localparam int unsigned INDEX_LEN   = ADDRESS_LEN - 3;
  localparam int unsigned CNT_LEN     = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t FILL   = 2'd1;
  localparam state_t UPDATE = 2'd2;
  localparam state_t WRITE  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_controller.sv
// Cache/memory sequencer: read-allocate with 4-word line fill, write-through without allocate.
module cache_controller
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_rd_en,
  input  logic                   cpu_wr_en,
  input  logic [ADDRESS_LEN-1:0] cpu_addr,
  input  logic [WORD_LEN-1:0]    cpu_wdata,
  output logic [WORD_LEN-1:0]    cpu_rdata,
  output logic                   cpu_ready,
  input  logic                   cache_miss,
  input  logic [WORD_LEN-1:0]    cache_rdata,
  output logic [ADDRESS_LEN-1:0] cache_addr,
  output logic                   cache_read_en,
  output logic                   cache_write_en,
  output logic                   cache_invalid,
  output logic [BLOCK_LEN-1:0]   cache_block,
  output logic                   mem_rd_en,
  output logic                   mem_wr_en,
  output logic [ADDRESS_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0]    mem_wdata,
  input  logic [WORD_LEN-1:0]    mem_rdata,
  input  logic                   mem_ready,
  output logic [CNT_LEN-1:0]     hit_count,
  output logic [CNT_LEN-1:0]     miss_count
);

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [BLOCK_LEN-1:0] buf_q, buf_d;
  logic                 hit_inc, miss_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    buf_d          = buf_q;
    cpu_ready      = 1'b0;
    cache_read_en  = 1'b0;
    cache_write_en = 1'b0;
    cache_invalid  = 1'b0;
    mem_rd_en      = 1'b0;
    mem_wr_en      = 1'b0;
    mem_addr       = cpu_addr;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        cache_read_en = cpu_rd_en;
        // Writes take priority; a resident line is dropped rather than updated.
        if (cpu_wr_en) begin
          cache_invalid = !cache_miss;
          state_d       = WRITE;
        end else if (cpu_rd_en) begin
          if (!cache_miss) begin
            cpu_ready = 1'b1;
            hit_inc   = 1'b1;
          end else begin
            miss_inc = 1'b1;
            cnt_d    = 2'd0;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        mem_rd_en = 1'b1;
        mem_addr  = {cpu_addr[ADDRESS_LEN-1:2], cnt_q};
        if (mem_ready) begin
          buf_d[cnt_q*WORD_LEN +: WORD_LEN] = mem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        cache_write_en = 1'b1;
        state_d        = IDLE;
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        if (mem_ready) begin
          cpu_ready = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rdata   = cache_rdata;
  assign cache_addr  = cpu_addr;
  assign cache_block = buf_q;
  assign mem_wdata   = cpu_wdata;

  sat_counter #(
    .WIDTH(CNT_LEN)
  ) u_hit_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit_inc),
    .count(hit_count)
  );

  sat_counter #(
    .WIDTH(CNT_LEN)
  ) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (miss_inc),
    .count(miss_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache array and 3-cycle memory.
module tb_cache_controller;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_rd_en = 1'b0;
  logic          cpu_wr_en = 1'b0;
  logic [17:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          cache_miss;
  logic [31:0]   cache_rdata;
  logic [17:0]   cache_addr;
  logic          cache_read_en;
  logic          cache_write_en;
  logic          cache_invalid;
  logic [127:0]  cache_block;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [17:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_rd_en     (cpu_rd_en),
    .cpu_wr_en     (cpu_wr_en),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ready     (cpu_ready),
    .cache_miss    (cache_miss),
    .cache_rdata   (cache_rdata),
    .cache_addr    (cache_addr),
    .cache_read_en (cache_read_en),
    .cache_write_en(cache_write_en),
    .cache_invalid (cache_invalid),
    .cache_block   (cache_block),
    .mem_rd_en     (mem_rd_en),
    .mem_wr_en     (mem_wr_en),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return 32'h5A00_0000 + {14'd0, a};
  endfunction

  // Direct-mapped cache array model: index addr[16:2], tag addr[17].
  bit           valid_a [0:32767];
  logic         tag_a   [0:32767];
  logic [127:0] data_a  [0:32767];
  logic [14:0]  idx;
  assign idx         = cache_addr[16:2];
  assign cache_miss  = !(valid_a[idx] && (tag_a[idx] == cache_addr[17]));
  assign cache_rdata = data_a[idx][cache_addr[1:0]*32 +: 32];

  always @(posedge clk) begin
    if (cache_write_en) begin
      valid_a[idx] <= 1'b1;
      tag_a[idx]   <= cache_addr[17];
      data_a[idx]  <= cache_block;
    end
    if (cache_invalid) valid_a[idx] <= 1'b0;
  end

  // Memory model: completes each request with a one-cycle mem_ready after two wait cycles.
  logic [17:0] rd_log[$];
  logic [17:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          mem_wait;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mem_wait  <= 0;
    end else begin
      mem_ready <= 1'b0;
      if ((mem_rd_en || mem_wr_en) && !mem_ready) begin
        if (mem_wait == 1) begin
          mem_ready <= 1'b1;
          mem_wait  <= 0;
          if (mem_rd_en) begin
            mem_rdata <= mem_word(mem_addr);
            rd_log.push_back(mem_addr);
          end else begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
          end
        end else begin
          mem_wait <= mem_wait + 1;
        end
      end
    end
  end

  int fill_cnt    = 0;
  int overlap_cnt = 0;
  always @(posedge clk) begin
    if (cache_write_en) fill_cnt++;
    if (mem_rd_en && mem_wr_en) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (cpu_ready !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int fills0;
  int rd0;
  int k;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_ready", cpu_ready, 0);
    chk("rst_mem_rd", mem_rd_en, 0);
    chk("rst_mem_wr", mem_wr_en, 0);
    chk("rst_fill_strobe", cache_write_en, 0);
    chk("rst_block", cache_block, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    rst = 1'b1;
    tick();

    // Cold read 0x00005: full line fetch 0x4..0x7
    fills0 = fill_cnt;
    cpu_addr = 18'h00005; cpu_rd_en = 1'b1;
    #1;
    chk("cold_req_ready", cpu_ready, 0);
    chk("cold_read_en", cache_read_en, 1);
    wait_ready(lat);
    chk("cold_ready", cpu_ready, 1);
    chk("cold_latency", lat, 14);
    chk("cold_data", cpu_rdata, mem_word(18'h00005));
    chk("cold_rd_count", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("cold_rd_addr", rd_log[i], 18'h4 + i);
    chk("cold_fill_once", fill_cnt - fills0, 1);
    tick();
    cpu_rd_en = 1'b0;
    chk("cold_misses", miss_count, 1);
    chk("cold_hits", hit_count, 1);

    // Re-read 0x00006: same-cycle hit
    rd0 = rd_log.size();
    cpu_addr = 18'h00006; cpu_rd_en = 1'b1;
    #1;
    chk("hit_ready", cpu_ready, 1);
    chk("hit_no_mem", mem_rd_en, 0);
    chk("hit_data", cpu_rdata, mem_word(18'h00006));
    tick();
    cpu_rd_en = 1'b0;
    chk("hit_hits", hit_count, 2);
    chk("hit_no_fetch", rd_log.size() - rd0, 0);

    // Write 0x00005: invalidates the line, then writes memory
    cpu_addr = 18'h00005; cpu_wdata = 32'hDEAD_BEEF; cpu_wr_en = 1'b1;
    #1;
    chk("wr_invalid", cache_invalid, 1);
    chk("wr_req_ready", cpu_ready, 0);
    tick();
    chk("wr_mem_en", mem_wr_en, 1);
    chk("wr_inv_one_cycle", cache_invalid, 0);
    wait_ready(lat);
    chk("wr_ready", cpu_ready, 1);
    chk("wr_addr", wr_addr_log[$], 18'h00005);
    chk("wr_data", wr_data_log[$], 32'hDEAD_BEEF);
    tick();
    cpu_wr_en = 1'b0;
    cpu_rd_en = 1'b1;
    #1;
    chk("after_wr_miss", cpu_ready, 0);
    wait_ready(lat);
    chk("after_wr_ready", cpu_ready, 1);
    tick();
    cpu_rd_en = 1'b0;
    chk("after_wr_misses", miss_count, 2);

    // Write 0x20005: tag mismatch, line stays valid
    cpu_addr = 18'h20005; cpu_wdata = 32'h1234_5678; cpu_wr_en = 1'b1;
    #1;
    chk("wr2_no_invalid", cache_invalid, 0);
    wait_ready(lat);
    chk("wr2_ready", cpu_ready, 1);
    chk("wr2_addr", wr_addr_log[$], 18'h20005);
    chk("wr2_data", wr_data_log[$], 32'h1234_5678);
    tick();
    cpu_wr_en = 1'b0;
    cpu_addr = 18'h00005; cpu_rd_en = 1'b1;
    #1;
    chk("wr2_still_hit", cpu_ready, 1);
    tick();
    cpu_rd_en = 1'b0;

    // Reset during the third fill word
    fills0 = fill_cnt;
    cpu_addr = 18'h00010; cpu_rd_en = 1'b1;
    k = 0;
    while (!(mem_rd_en === 1'b1 && mem_addr === 18'h00012) && k < 200) begin
      tick();
      k++;
    end
    chk("rst_mid_reach", mem_addr, 18'h00012);
    rst = 1'b0; cpu_rd_en = 1'b0;
    #1;
    chk("rst_mid_mem_rd", mem_rd_en, 0);
    chk("rst_mid_misses", miss_count, 0);
    tick();
    chk("rst_mid_no_fill", fill_cnt - fills0, 0);
    rst = 1'b1;
    tick();
    rd0 = rd_log.size();
    cpu_rd_en = 1'b1;
    #1;
    chk("refetch_miss", cpu_ready, 0);
    wait_ready(lat);
    chk("refetch_latency", lat, 14);
    chk("refetch_count", rd_log.size() - rd0, 4);
    for (int i = 0; i < 4; i++) chk("refetch_addr", rd_log[rd0 + i], 18'h10 + i);
    chk("refetch_data", cpu_rdata, mem_word(18'h00010));
    tick();
    cpu_rd_en = 1'b0;
    chk("refetch_misses", miss_count, 1);
    chk("refetch_hits", hit_count, 1);

    // Read and write together: write path only
    cpu_addr = 18'h00010; cpu_wdata = 32'hCAFE_F00D;
    cpu_rd_en = 1'b1; cpu_wr_en = 1'b1;
    #1;
    chk("both_invalid", cache_invalid, 1);
    chk("both_no_ready", cpu_ready, 0);
    tick();
    chk("both_mem_wr", mem_wr_en, 1);
    chk("both_no_mem_rd", mem_rd_en, 0);
    wait_ready(lat);
    chk("both_ready", cpu_ready, 1);
    chk("both_wr_addr", wr_addr_log[$], 18'h00010);
    tick();
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    chk("both_hits", hit_count, 1);
    chk("both_misses", miss_count, 1);

    // Hit counter saturation
    cpu_addr = 18'h00020; cpu_rd_en = 1'b1;
    wait_ready(lat);
    chk("sat_fill_ready", cpu_ready, 1);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_hits", hit_count, 16'hFFFF);
    tick();
    tick();
    chk("sat_hits_hold", hit_count, 16'hFFFF);
    chk("sat_misses", miss_count, 2);
    cpu_rd_en = 1'b0;
    tick();
    chk("no_rd_wr_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
